// File: rtl/pc_ctrl.sv
// Fetch-stage program counter with next-PC selection and stall gating.
// Debug run/halt/step FSM freezes the core or advances N PC updates.
module pc_ctrl #(
  parameter int unsigned NBITS        = 32,
  parameter int unsigned INC          = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] EXC_VECTOR   = 32'h80,
  parameter int unsigned CNTW         = 16,
  parameter bit          START_HALTED = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_exception,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_target,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_dbg_halt,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  input  logic [CNTW-1:0]  i_dbg_step_cnt,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_PC_plus,
  output logic             o_valid,
  output logic [1:0]       o_state,
  output logic             o_step_done,
  output logic [CNTW-1:0]  o_adv_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } state_t;

  localparam logic [NBITS-1:0] RST_PC = NBITS'(RESET_VECTOR);
  localparam logic [NBITS-1:0] EXC_PC = NBITS'(EXC_VECTOR);
  localparam logic [NBITS-1:0] INC_V  = NBITS'(INC);
  localparam state_t           RST_ST = START_HALTED ? HALT : RUN;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  pc_q, pc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0]   adv_q, adv_d;
  logic              done_q, done_d;
  logic              adv;

  assign adv       = (state_q != HALT) && (i_exception || !i_stall);
  assign o_PC      = pc_q;
  assign o_PC_plus = pc_q + INC_V;
  assign o_valid   = (state_q != HALT);
  assign o_state   = state_q;
  assign o_step_done = done_q;
  assign o_adv_cnt = adv_q;

  // Next-PC priority mux and update counter
  always_comb begin
    pc_d  = pc_q;
    adv_d = adv_q;
    if (adv) begin
      adv_d = adv_q + CNTW'(1);
      if (i_exception)         pc_d = EXC_PC;
      else if (i_jump)         pc_d = i_jump_target;
      else if (i_branch_taken) pc_d = i_branch_target;
      else                     pc_d = pc_q + INC_V;
    end
  end

  // Debug FSM next state, step counter and completion pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (i_dbg_halt) state_d = HALT;
      end
      HALT: begin
        if (i_dbg_halt) begin
          state_d = HALT;
        end else if (i_dbg_run) begin
          state_d = RUN;
        end else if (i_dbg_step && (i_dbg_step_cnt != '0)) begin
          state_d = STEP;
          cnt_d   = i_dbg_step_cnt;
        end
      end
      STEP: begin
        if (i_dbg_halt) begin
          state_d = HALT;
          cnt_d   = '0;
        end else if (adv) begin
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = HALT;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = HALT;
        cnt_d   = '0;
      end
    endcase
  end

  // Falling-edge register bank with synchronous reset
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      state_q <= RST_ST;
      pc_q    <= RST_PC;
      cnt_q   <= '0;
      adv_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: 32-bit run-at-reset unit and an
// 8-bit halted-at-reset unit for wrap and reset-mid-step cases.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, exc, jmp, br, dh, dr, ds;
  logic [31:0] jt, bt;
  logic [15:0] dsc;
  logic [31:0] pc, pcp;
  logic        vld, sd;
  logic [1:0]  st;
  logic [15:0] ac;

  logic        r8, s8, e8, j8, b8, h8, ru8, sp8;
  logic [7:0]  jt8, bt8;
  logic [15:0] sc8;
  logic [7:0]  pc8, pcp8;
  logic        vld8, sd8;
  logic [1:0]  st8;
  logic [15:0] ac8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_ctrl #(
    .NBITS(32), .INC(4), .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h80), .CNTW(16), .START_HALTED(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall),
    .i_exception(exc), .i_jump(jmp), .i_jump_target(jt),
    .i_branch_taken(br), .i_branch_target(bt),
    .i_dbg_halt(dh), .i_dbg_run(dr), .i_dbg_step(ds),
    .i_dbg_step_cnt(dsc), .o_PC(pc), .o_PC_plus(pcp),
    .o_valid(vld), .o_state(st), .o_step_done(sd),
    .o_adv_cnt(ac)
  );

  pc_ctrl #(
    .NBITS(8), .INC(4), .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h80), .CNTW(16), .START_HALTED(1'b1)
  ) dut8 (
    .i_clk(clk), .i_reset(r8), .i_stall(s8),
    .i_exception(e8), .i_jump(j8), .i_jump_target(jt8),
    .i_branch_taken(b8), .i_branch_target(bt8),
    .i_dbg_halt(h8), .i_dbg_run(ru8), .i_dbg_step(sp8),
    .i_dbg_step_cnt(sc8), .o_PC(pc8), .o_PC_plus(pcp8),
    .o_valid(vld8), .o_state(st8), .o_step_done(sd8),
    .o_adv_cnt(ac8)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; exc = 0; jmp = 0; br = 0;
    dh = 0; dr = 0; ds = 0; jt = 0; bt = 0; dsc = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    n_cmp++;
    if (pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_pc got %h want %h", pc, 32'h0);
    end
    n_cmp++;
    if (st !== 2'b00) begin
      n_err++;
      $display("FAIL reset_state got %b want %b", st, 2'b00);
    end
    n_cmp++;
    if (ac !== 16'd0 || sd !== 1'b0 || vld !== 1'b1) begin
      n_err++;
      $display("FAIL reset_misc got ac=%0d sd=%b v=%b want 0 0 1",
               ac, sd, vld);
    end
    n_cmp++;
    if (pcp !== 32'h4) begin
      n_err++;
      $display("FAIL reset_pcplus got %h want %h", pcp, 32'h4);
    end
    rst = 0;
  endtask

  task automatic test_seq();
    logic [31:0] exp;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = 32'(i * 4);
      n_cmp++;
      if (pc !== exp) begin
        n_err++;
        $display("FAIL seq_pc%0d got %h want %h", i, pc, exp);
      end
    end
    n_cmp++;
    if (ac !== 16'd5) begin
      n_err++;
      $display("FAIL seq_adv got %0d want 5", ac);
    end
  endtask

  task automatic test_stall_jump();
    jmp = 1; jt = 32'h10;
    tick();
    clr();
    n_cmp++;
    if (pc !== 32'h10) begin
      n_err++;
      $display("FAIL jump_pc got %h want %h", pc, 32'h10);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (pc !== 32'h10) begin
        n_err++;
        $display("FAIL stall_pc%0d got %h want %h", i, pc, 32'h10);
      end
    end
    n_cmp++;
    if (ac !== 16'd6) begin
      n_err++;
      $display("FAIL stall_adv got %0d want 6", ac);
    end
    stall = 0;
    jmp = 1; jt = 32'h40; br = 1; bt = 32'h80;
    tick();
    clr();
    n_cmp++;
    if (pc !== 32'h40) begin
      n_err++;
      $display("FAIL jump_over_branch got %h want %h", pc, 32'h40);
    end
    br = 1; bt = 32'h100;
    tick();
    clr();
    n_cmp++;
    if (pc !== 32'h100 || ac !== 16'd8) begin
      n_err++;
      $display("FAIL branch got pc=%h ac=%0d want 100 8", pc, ac);
    end
  endtask

  task automatic test_exception();
    stall = 1; exc = 1; jmp = 1; jt = 32'h40;
    tick();
    clr();
    n_cmp++;
    if (pc !== 32'h80 || ac !== 16'd9) begin
      n_err++;
      $display("FAIL exc_pc got pc=%h ac=%0d want 80 9", pc, ac);
    end
  endtask

  task automatic test_step();
    jmp = 1; jt = 32'h20; dh = 1;
    tick();
    clr();
    n_cmp++;
    if (pc !== 32'h20 || st !== 2'b01 || vld !== 1'b0) begin
      n_err++;
      $display("FAIL halt_edge got pc=%h st=%b v=%b want 20 01 0",
               pc, st, vld);
    end
    stall = 0;
    tick();
    n_cmp++;
    if (pc !== 32'h20 || ac !== 16'd10) begin
      n_err++;
      $display("FAIL halt_hold got pc=%h ac=%0d want 20 10", pc, ac);
    end
    ds = 1; dsc = 16'd3;
    tick();
    clr();
    n_cmp++;
    if (st !== 2'b10 || pc !== 32'h20) begin
      n_err++;
      $display("FAIL step_enter got st=%b pc=%h want 10 20", st, pc);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h24 || sd !== 1'b0) begin
      n_err++;
      $display("FAIL step_e1 got pc=%h sd=%b want 24 0", pc, sd);
    end
    stall = 1;
    tick();
    stall = 0;
    n_cmp++;
    if (pc !== 32'h24 || st !== 2'b10) begin
      n_err++;
      $display("FAIL step_e2 got pc=%h st=%b want 24 10", pc, st);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h28 || sd !== 1'b0) begin
      n_err++;
      $display("FAIL step_e3 got pc=%h sd=%b want 28 0", pc, sd);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h2C || st !== 2'b01 || sd !== 1'b1) begin
      n_err++;
      $display("FAIL step_e4 got pc=%h st=%b sd=%b want 2c 01 1",
               pc, st, sd);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h2C || sd !== 1'b0 || ac !== 16'd13) begin
      n_err++;
      $display("FAIL step_after got pc=%h sd=%b ac=%0d want 2c 0 13",
               pc, sd, ac);
    end
  endtask

  task automatic test_step_abort();
    ds = 1; dsc = 16'd5;
    tick();
    clr();
    tick();
    tick();
    n_cmp++;
    if (pc !== 32'h34 || st !== 2'b10) begin
      n_err++;
      $display("FAIL abort_pre got pc=%h st=%b want 34 10", pc, st);
    end
    dh = 1;
    tick();
    clr();
    n_cmp++;
    if (st !== 2'b01 || sd !== 1'b0 || pc !== 32'h38) begin
      n_err++;
      $display("FAIL abort_halt got st=%b sd=%b pc=%h want 01 0 38",
               st, sd, pc);
    end
    tick();
    n_cmp++;
    if (sd !== 1'b0 || pc !== 32'h38) begin
      n_err++;
      $display("FAIL abort_nodone got sd=%b pc=%h want 0 38", sd, pc);
    end
    dh = 1; dr = 1;
    tick();
    clr();
    n_cmp++;
    if (st !== 2'b01) begin
      n_err++;
      $display("FAIL halt_wins got %b want 01", st);
    end
    ds = 1; dsc = 16'd0;
    tick();
    clr();
    n_cmp++;
    if (st !== 2'b01 || pc !== 32'h38) begin
      n_err++;
      $display("FAIL step_zero got st=%b pc=%h want 01 38", st, pc);
    end
    dr = 1; ds = 1; dsc = 16'd2;
    tick();
    clr();
    n_cmp++;
    if (st !== 2'b00 || pc !== 32'h38) begin
      n_err++;
      $display("FAIL run_wins got st=%b pc=%h want 00 38", st, pc);
    end
    tick();
    n_cmp++;
    if (pc !== 32'h3C || ac !== 16'd17) begin
      n_err++;
      $display("FAIL run_resume got pc=%h ac=%0d want 3c 17", pc, ac);
    end
  endtask

  task automatic test_wrap8();
    r8 = 1;
    tick();
    n_cmp++;
    if (pc8 !== 8'h00 || st8 !== 2'b01 || vld8 !== 1'b0) begin
      n_err++;
      $display("FAIL w8_reset got pc=%h st=%b v=%b want 00 01 0",
               pc8, st8, vld8);
    end
    r8 = 0; ru8 = 1;
    tick();
    ru8 = 0;
    n_cmp++;
    if (pc8 !== 8'h00 || st8 !== 2'b00) begin
      n_err++;
      $display("FAIL w8_run got pc=%h st=%b want 00 00", pc8, st8);
    end
    j8 = 1; jt8 = 8'hFC;
    tick();
    j8 = 0;
    n_cmp++;
    if (pc8 !== 8'hFC || pcp8 !== 8'h00) begin
      n_err++;
      $display("FAIL w8_top got pc=%h plus=%h want fc 00", pc8, pcp8);
    end
    tick();
    n_cmp++;
    if (pc8 !== 8'h00) begin
      n_err++;
      $display("FAIL w8_wrap got %h want 00", pc8);
    end
    e8 = 1;
    tick();
    e8 = 0;
    n_cmp++;
    if (pc8 !== 8'h80) begin
      n_err++;
      $display("FAIL w8_exc got %h want 80", pc8);
    end
    h8 = 1;
    tick();
    h8 = 0;
    sp8 = 1; sc8 = 16'd4;
    tick();
    sp8 = 0; sc8 = 0;
    tick();
    n_cmp++;
    if (pc8 !== 8'h88 || st8 !== 2'b10) begin
      n_err++;
      $display("FAIL w8_step got pc=%h st=%b want 88 10", pc8, st8);
    end
    r8 = 1;
    tick();
    r8 = 0;
    n_cmp++;
    if (pc8 !== 8'h00 || st8 !== 2'b01 || sd8 !== 1'b0 ||
        ac8 !== 16'd0) begin
      n_err++;
      $display("FAIL w8_rst_step got pc=%h st=%b sd=%b ac=%0d want 00 01 0 0",
               pc8, st8, sd8, ac8);
    end
    tick();
    n_cmp++;
    if (sd8 !== 1'b0 || st8 !== 2'b01 || pc8 !== 8'h00) begin
      n_err++;
      $display("FAIL w8_post got sd=%b st=%b pc=%h want 0 01 00",
               sd8, st8, pc8);
    end
  endtask

  initial begin
    clr();
    rst = 1;
    r8 = 1; s8 = 0; e8 = 0; j8 = 0; b8 = 0; h8 = 0;
    ru8 = 0; sp8 = 0; jt8 = 0; bt8 = 0; sc8 = 0;
    test_reset();
    test_seq();
    test_stall_jump();
    test_exception();
    test_step();
    test_step_abort();
    test_wrap8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
